vend_dispenser: RTL and testbench
=================================

Name: vend_dispenser

Overview:
- Downstream consumer of the vending FSM's one-cycle `out` (vend) and `change` indications.
- Queues each dispense request and drives the physical actuators: the product motor and the 5-unit coin ejector.
- Sequences actuator timing, waits for a product-drop sensor, and detects timeouts and an empty hopper.
- Reports busy, fault, overflow and completion status back to the controller.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- MOTOR_CYC, 4, cycles motor_on is held per product vend.
- DROP_TMO, 16, maximum cycles to wait for drop_sense after the motor stops.
- COIN_CYC, 2, cycles coin_eject is held per coin.
- GAP_CYC, 3, idle cycles between consecutive coin ejects.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- vend  in  1  product-release indication from the vending FSM; sampled every cycle.
- change  in  2  coin count to return: 00 none, 01 one coin, 10 two coins, 11 three coins; sampled every cycle.
- drop_sense  in  1  product-drop optical sensor, high when the product has fallen.
- hopper_empty  in  1  coin hopper empty switch.
- fault_clr  in  1  one-cycle pulse; leaves FAULT and clears overflow.
- motor_on  out  1  product motor drive.
- coin_eject  out  1  coin solenoid drive.
- busy  out  1  high in any state other than IDLE, or while the FIFO is non-empty.
- fault  out  1  high while in FAULT.
- overflow  out  1  sticky; a request was dropped because the FIFO was full.
- dispense_done  out  1  one-cycle pulse when a request has been fully served.
- pend_count  out  $clog2(DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (rst=1 at a posedge):
  - State goes to IDLE and the FIFO is emptied.
  - All outputs go to 0 on that edge, including mid-motor or mid-eject.
  - The in-flight request is lost.
- Request capture:
  - Any cycle with vend=1 or change≠00 pushes one 3-bit entry {vend,change} at the posedge.
  - Back-to-back nonzero cycles give separate entries.
  - vend=0 with change=00 is never enqueued.
- FIFO:
  - Circular, with read/write pointers and a count.
  - Full is judged on count after any same-cycle pop, so push and pop together when full is accepted.
  - A push while full with no pop is dropped and sets overflow.
  - Capture continues in every state, including FAULT.
- Timer: one shared 16-bit down counter. All outputs are registered; actuator outputs are asserted in the cycles the FSM occupies the state.
- IDLE:
  - If the FIFO is non-empty, pop the head into cur_vend and cur_coins.
  - Next state is MOTOR if cur_vend=1, otherwise COIN_ON.
- MOTOR:
  - motor_on=1 for exactly MOTOR_CYC cycles, then go to WAIT_DROP.
- WAIT_DROP:
  - motor_on=0.
  - If drop_sense=1 within DROP_TMO cycles: go to COIN_ON if cur_coins>0, otherwise go to IDLE and pulse dispense_done.
  - If the count expires without drop_sense, go to FAULT.
- COIN_ON:
  - On entry, if hopper_empty=1, go to FAULT immediately with coin_eject kept 0.
  - Otherwise coin_eject=1 for COIN_CYC cycles, decrement cur_coins, and go to COIN_GAP.
- COIN_GAP:
  - coin_eject=0 for GAP_CYC cycles.
  - Then go to COIN_ON if cur_coins>0, otherwise go to IDLE and pulse dispense_done.
- FAULT:
  - fault=1; motor_on and coin_eject are held 0; the current request is discarded with no dispense_done.
  - Stay until fault_clr=1, then go to IDLE; queued entries are then served normally.
- fault_clr outside FAULT clears overflow only.
- Simultaneous events:
  - fault_clr and a push in the same cycle: both take effect.
  - rst overrides everything.

Test Plan:
- vend=1, change=00 for 1 cycle; drop_sense raised 3 cycles after the motor stops -> motor_on high exactly 4 cycles, one dispense_done, busy falls to 0, pend_count back to 0.
- vend=0, change=10 for 1 cycle, hopper_empty=0 -> coin_eject pattern 2 on / 3 off / 2 on / 3 off, then dispense_done; motor_on never asserted.
- vend=1, change=01; drop_sense held 0 -> after 4 motor cycles plus 16 wait cycles, fault=1, no coin_eject, no dispense_done; fault_clr -> IDLE.
- Five nonzero requests on consecutive cycles while the block is busy -> pend_count saturates at 4 and overflow=1; after all four are served, overflow is still 1 until fault_clr.
- change=11 with hopper_empty rising after the first coin -> exactly one coin_eject burst, then fault=1, motor_on=0.
- rst asserted during the 2nd MOTOR cycle with 2 queued entries -> motor_on=0, pend_count=0, busy=0 on the next edge, and no dispense_done.

Source files
------------

// File: rtl/vend_dispenser.sv
// Vending dispenser back end: queues {vend,change} requests and sequences the
// product motor and coin ejector, with drop-sensor timeout and empty-hopper faults.
module vend_dispenser #(
    parameter int DEPTH     = 4,
    parameter int MOTOR_CYC = 4,
    parameter int DROP_TMO  = 16,
    parameter int COIN_CYC  = 2,
    parameter int GAP_CYC   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vend,
    input  logic [1:0]               change,
    input  logic                     drop_sense,
    input  logic                     hopper_empty,
    input  logic                     fault_clr,
    output logic                     motor_on,
    output logic                     coin_eject,
    output logic                     busy,
    output logic                     fault,
    output logic                     overflow,
    output logic                     dispense_done,
    output logic [$clog2(DEPTH):0]   pend_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOTOR     = 3'd1,
        WAIT_DROP = 3'd2,
        COIN_ON   = 3'd3,
        COIN_GAP  = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t          state_r, state_s;
    logic [2:0]      fifo_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, count_s;
    logic [15:0]     timer_r, timer_s;
    logic [1:0]      cur_coins_r, cur_coins_s;
    logic            push_s, pop_s, accept_s, done_s, go_coin_s;
    logic [2:0]      head_s;

    // Request FIFO control; fullness is judged after a same-cycle pop.
    always_comb begin
        push_s   = vend | (change != 2'b00);
        pop_s    = (state_r == IDLE) && (count_r != {CW{1'b0}});
        accept_s = push_s && ((count_r - CW'(pop_s)) < CW'(DEPTH));
        count_s  = count_r + CW'(accept_s) - CW'(pop_s);
        head_s   = fifo_r[rd_ptr_r];
    end

    // Next-state, timer and coin bookkeeping.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        cur_coins_s = cur_coins_r;
        done_s      = 1'b0;
        go_coin_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    cur_coins_s = head_s[1:0];
                    if (head_s[2]) begin
                        state_s = MOTOR;
                        timer_s = 16'(MOTOR_CYC - 1);
                    end else begin
                        go_coin_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MOTOR: begin
                if (timer_r == 16'd0) begin
                    state_s = WAIT_DROP;
                    timer_s = 16'(DROP_TMO - 1);
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            WAIT_DROP: begin
                if (drop_sense) begin
                    if (cur_coins_r != 2'd0) begin
                        go_coin_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end
                end else if (timer_r == 16'd0) begin
                    state_s = FAULT;
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            COIN_ON: begin
                if (timer_r == 16'd0) begin
                    cur_coins_s = cur_coins_r - 2'd1;
                    state_s     = COIN_GAP;
                    timer_s     = 16'(GAP_CYC - 1);
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            COIN_GAP: begin
                if (timer_r != 16'd0) begin
                    timer_s = timer_r - 16'd1;
                end else if (cur_coins_r != 2'd0) begin
                    go_coin_s = 1'b1;
                end else begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_s = IDLE;
                end else begin
                    state_s = FAULT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Hopper is checked as COIN_ON is entered so an empty hopper never pulses the solenoid.
        if (go_coin_s) begin
            if (hopper_empty) begin
                state_s = FAULT;
            end else begin
                state_s = COIN_ON;
                timer_s = 16'(COIN_CYC - 1);
            end
        end else begin
            state_s = state_s;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            fifo_r[wr_ptr_r] <= {vend, change};
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
            timer_r       <= 16'd0;
            cur_coins_r   <= 2'd0;
            motor_on      <= 1'b0;
            coin_eject    <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
            overflow      <= 1'b0;
            dispense_done <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            cur_coins_r   <= cur_coins_s;
            count_r       <= count_s;
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            if (push_s && !accept_s) begin
                overflow <= 1'b1;
            end else if (fault_clr) begin
                overflow <= 1'b0;
            end
            motor_on      <= (state_s == MOTOR);
            coin_eject    <= (state_s == COIN_ON);
            fault         <= (state_s == FAULT);
            busy          <= (state_s != IDLE) || (count_s != {CW{1'b0}});
            dispense_done <= done_s;
        end
    end

    assign pend_count = count_r;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed self-checking bench for vend_dispenser; inputs change and outputs
// are sampled on the falling edge.
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       rst, vend, drop_sense, hopper_empty, fault_clr;
    logic [1:0] change;
    logic       motor_on, coin_eject, busy, fault, overflow, dispense_done;
    logic [2:0] pend_count;

    int checks = 0;
    int errors = 0;

    vend_dispenser dut (
        .clk(clk), .rst(rst), .vend(vend), .change(change),
        .drop_sense(drop_sense), .hopper_empty(hopper_empty), .fault_clr(fault_clr),
        .motor_on(motor_on), .coin_eject(coin_eject), .busy(busy), .fault(fault),
        .overflow(overflow), .dispense_done(dispense_done), .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expo(input string tag, input logic m, input logic c, input logic b,
                        input logic f, input logic o, input logic d, input logic [2:0] p);
        logic [8:0] obs, ex;
        obs = {motor_on, coin_eject, busy, fault, overflow, dispense_done, pend_count};
        ex  = {m, c, b, f, o, d, p};
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: observed motor/coin/busy/fault/ovf/done=%b%b%b%b%b%b pend=%0d, expected %b%b%b%b%b%b pend=%0d",
                   tag, obs[8], obs[7], obs[6], obs[5], obs[4], obs[3], obs[2:0],
                   m, c, b, f, o, d, p);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int ex);
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, ex);
        end
    endtask

    initial begin
        logic [10:0] pat2;
        logic [2:0]  pe;
        int          n_done;
        int          k;

        rst = 1'b1; vend = 1'b0; change = 2'b00; drop_sense = 1'b0;
        hopper_empty = 1'b0; fault_clr = 1'b0;
        step(); step();
        expo("reset", 0, 0, 0, 0, 0, 0, 3'd0);
        rst = 1'b0;

        // Product only, drop seen after three wait cycles.
        vend = 1'b1; step(); vend = 1'b0;
        expo("t1 push", 0, 0, 1, 0, 0, 0, 3'd1);
        for (int i = 0; i < 4; i++) begin
            step(); expo("t1 motor", 1, 0, 1, 0, 0, 0, 3'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(); expo("t1 wait", 0, 0, 1, 0, 0, 0, 3'd0);
        end
        drop_sense = 1'b1; step(); drop_sense = 1'b0;
        expo("t1 done", 0, 0, 0, 0, 0, 1, 3'd0);
        step(); expo("t1 idle", 0, 0, 0, 0, 0, 0, 3'd0);

        // Two coins: 2 on / 3 off / 2 on / 3 off, then done.
        change = 2'b10; step(); change = 2'b00;
        expo("t2 push", 0, 0, 1, 0, 0, 0, 3'd1);
        pat2 = 11'b11000110000;
        for (int i = 0; i < 11; i++) begin
            step();
            expo("t2 coin", 0, pat2[10-i], (i != 10), 0, 0, (i == 10), 3'd0);
        end

        // Drop timeout -> fault, coin never ejected.
        vend = 1'b1; change = 2'b01; step(); vend = 1'b0; change = 2'b00;
        expo("t3 push", 0, 0, 1, 0, 0, 0, 3'd1);
        for (int i = 0; i < 20; i++) begin
            step(); expo("t3 run", (i < 4), 0, 1, 0, 0, 0, 3'd0);
        end
        step(); expo("t3 fault", 0, 0, 1, 1, 0, 0, 3'd0);
        step(); expo("t3 hold", 0, 0, 1, 1, 0, 0, 3'd0);
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        expo("t3 clr", 0, 0, 0, 0, 0, 0, 3'd0);

        // Overflow while busy; sticky until fault_clr.
        drop_sense = 1'b1;
        vend = 1'b1; step(); vend = 1'b0;
        expo("t4 first", 0, 0, 1, 0, 0, 0, 3'd1);
        for (int i = 0; i < 5; i++) begin
            change = 2'b01; step();
            pe = (i < 4) ? 3'(i + 1) : 3'd4;
            expo("t4 fill", (i < 4), 0, 1, 0, (i == 4), 0, pe);
        end
        change = 2'b00;
        n_done = 0; k = 0;
        do begin
            step();
            if (dispense_done) n_done++;
            k++;
        end while (busy && k < 300);
        chk("t4 drain bound", int'(busy), 0);
        chk("t4 done count", n_done, 5);
        step(); expo("t4 drained", 0, 0, 0, 0, 1, 0, 3'd0);
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        expo("t4 ovf clr", 0, 0, 0, 0, 0, 0, 3'd0);
        drop_sense = 1'b0;

        // Hopper empties after the first of three coins.
        change = 2'b11; step(); change = 2'b00;
        expo("t5 push", 0, 0, 1, 0, 0, 0, 3'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            expo("t5 coin", 0, (i < 2), 1, (i == 5), 0, 0, 3'd0);
            if (i == 2) hopper_empty = 1'b1;
        end
        step(); expo("t5 hold", 0, 0, 1, 1, 0, 0, 3'd0);
        hopper_empty = 1'b0; fault_clr = 1'b1; step(); fault_clr = 1'b0;
        expo("t5 clr", 0, 0, 0, 0, 0, 0, 3'd0);

        // Reset in the second motor cycle with two entries queued.
        vend = 1'b1; step();
        expo("t6 q1", 0, 0, 1, 0, 0, 0, 3'd1);
        step(); expo("t6 m1", 1, 0, 1, 0, 0, 0, 3'd1);
        step(); vend = 1'b0;
        expo("t6 m2", 1, 0, 1, 0, 0, 0, 3'd2);
        rst = 1'b1; step(); rst = 1'b0;
        expo("t6 rst", 0, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step(); expo("t6 quiet", 0, 0, 0, 0, 0, 0, 3'd0);
        end

        // Capture during FAULT, then push+pop while full is accepted.
        hopper_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            change = 2'b01; step();
            pe = (i == 0) ? 3'd1 : 3'(i);
            expo("t7 fill", 0, 0, 1, (i > 0), 0, 0, pe);
        end
        change = 2'b00; fault_clr = 1'b1; step(); fault_clr = 1'b0;
        expo("t7 clr", 0, 0, 1, 0, 0, 0, 3'd4);
        change = 2'b01; step(); change = 2'b00;
        expo("t7 full push pop", 0, 0, 1, 1, 0, 0, 3'd4);
        rst = 1'b1; step(); rst = 1'b0; hopper_empty = 1'b0;
        expo("t7 rst", 0, 0, 0, 0, 0, 0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
